// File: rtl/muldiv_pkg.sv
// Shared encodings for the HI/LO multiply/divide unit: operation codes,
// FSM state names and the default iteration count.
package muldiv_pkg;

    localparam int MD_XLEN = 32;
    localparam int MD_ITER = 32;

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_MUL  = 2'b01,
        S_DIV  = 2'b10,
        S_FIX  = 2'b11
    } md_state_e;

endpackage

// File: rtl/pipe_muldiv_hilo_if.sv
// Decode-stage <-> multiply/divide unit port bundle.
interface pipe_muldiv_hilo_if #(
    parameter int XLEN = 32
);
    // start/mfhi/mflo/mthi/mtlo act as valid; ~stall acts as ready. A request
    // is consumed at the rising edge where it is asserted with stall=0;
    // decode keeps it asserted, unchanged, for as long as stall=1.
    logic            start;
    logic [1:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            mfhi;
    logic            mflo;
    logic            mthi;
    logic            mtlo;
    logic [XLEN-1:0] wd;
    logic [XLEN-1:0] rdata;
    logic            busy;
    logic            stall;

    modport master (
        output start, op, a, b, mfhi, mflo, mthi, mtlo, wd,
        input  rdata, busy, stall
    );

    modport slave (
        input  start, op, a, b, mfhi, mflo, mthi, mtlo, wd,
        output rdata, busy, stall
    );
endinterface

// File: rtl/muldiv_core.sv
// Iterative datapath: operand magnitudes, 64-bit accumulator and iteration
// counter. One shift-add or restoring-divide step per cycle while step=1.
module muldiv_core
    import muldiv_pkg::*;
#(
    parameter int XLEN = MD_XLEN,
    parameter int ITER = MD_ITER
) (
    input  logic              clk,
    input  logic              clrn,
    input  logic              load,
    input  logic              signed_op,
    input  logic [XLEN-1:0]   a,
    input  logic [XLEN-1:0]   b,
    input  logic              step,
    input  logic              is_div,
    output logic              done,
    output logic [2*XLEN-1:0] acc
);

    localparam int CW = $clog2(ITER);

    logic [XLEN-1:0]   mag_a_q, mag_a_d;
    logic [XLEN-1:0]   mag_b_q, mag_b_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [CW-1:0]     cnt_q, cnt_d;

    logic [XLEN:0]     sum;
    logic [XLEN:0]     rem_sh;
    logic [XLEN+1:0]   diff;
    logic              ge;

    always_comb begin
        mag_a_d = mag_a_q;
        mag_b_d = mag_b_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        sum     = '0;
        rem_sh  = '0;
        diff    = '0;
        ge      = 1'b0;
        if (load) begin
            mag_a_d = (signed_op && a[XLEN-1]) ? -a : a;
            mag_b_d = (signed_op && b[XLEN-1]) ? -b : b;
            acc_d   = '0;
            cnt_d   = '0;
        end else if (step) begin
            cnt_d = cnt_q + CW'(1);
            if (is_div) begin
                // Remainder lives in acc[hi], quotient bits shift into acc[lo];
                // dividend bits are fed from the top of mag_a.
                rem_sh  = {acc_q[2*XLEN-1:XLEN], mag_a_q[XLEN-1]};
                diff    = {1'b0, rem_sh} - {2'b00, mag_b_q};
                ge      = ~diff[XLEN+1];
                acc_d   = {(ge ? diff[XLEN-1:0] : rem_sh[XLEN-1:0]),
                           acc_q[XLEN-2:0], ge};
                mag_a_d = {mag_a_q[XLEN-2:0], 1'b0};
            end else begin
                sum     = {1'b0, acc_q[2*XLEN-1:XLEN]} +
                          {1'b0, (mag_b_q[0] ? mag_a_q : '0)};
                acc_d   = {sum, acc_q[XLEN-1:1]};
                mag_b_d = {1'b0, mag_b_q[XLEN-1:1]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!clrn) begin
            mag_a_q <= '0;
            mag_b_q <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            mag_a_q <= mag_a_d;
            mag_b_q <= mag_b_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

    assign done = (cnt_q == CW'(ITER - 1));
    assign acc  = acc_q;

endmodule

// File: rtl/pipe_muldiv_hilo.sv
// Multiply/divide unit owning HI/LO: sequencing FSM, sign fix-up, HI/LO
// registers, mfhi/mflo read mux and the decode-stage stall.
module pipe_muldiv_hilo
    import muldiv_pkg::*;
#(
    parameter int XLEN = MD_XLEN,
    parameter int ITER = MD_ITER
) (
    input  logic              clk,
    input  logic              clrn,
    pipe_muldiv_hilo_if.slave bus,
    output md_state_e         state_dbg
);

    md_state_e         state_q;
    logic              busy_q;
    logic [XLEN-1:0]   hi_q, hi_d;
    logic [XLEN-1:0]   lo_q, lo_d;
    logic              qneg_q, qneg_d;
    logic              rneg_q, rneg_d;
    logic              div_q, div_d;
    logic [2*XLEN-1:0] prod;

    logic              core_load;
    logic              core_step;
    logic              core_done;
    logic [2*XLEN-1:0] core_acc;

    assign core_load = (state_q == S_IDLE) && bus.start;
    assign core_step = (state_q == S_MUL) || (state_q == S_DIV);

    muldiv_core #(
        .XLEN (XLEN),
        .ITER (ITER)
    ) u_core (
        .clk       (clk),
        .clrn      (clrn),
        .load      (core_load),
        .signed_op (~bus.op[0]),
        .a         (bus.a),
        .b         (bus.b),
        .step      (core_step),
        .is_div    (state_q == S_DIV),
        .done      (core_done),
        .acc       (core_acc)
    );

    always_ff @(posedge clk) begin
        if (!clrn) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: if (bus.start) begin
                    state_q <= bus.op[1] ? S_DIV : S_MUL;
                    busy_q  <= 1'b1;
                end
                S_MUL, S_DIV: if (core_done) state_q <= S_FIX;
                S_FIX: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        hi_d   = hi_q;
        lo_d   = lo_q;
        qneg_d = qneg_q;
        rneg_d = rneg_q;
        div_d  = div_q;
        prod   = '0;
        if (state_q == S_IDLE) begin
            if (bus.mthi) hi_d = bus.wd;
            if (bus.mtlo) lo_d = bus.wd;
            if (bus.start) begin
                // A zero divisor leaves the all-ones quotient un-negated.
                qneg_d = ~bus.op[0] & (bus.a[XLEN-1] ^ bus.b[XLEN-1]) &
                         ~(bus.op[1] & (bus.b == '0));
                rneg_d = ~bus.op[0] & bus.a[XLEN-1];
                div_d  = bus.op[1];
            end
        end else if (state_q == S_FIX) begin
            if (div_q) begin
                hi_d = rneg_q ? -core_acc[2*XLEN-1:XLEN] : core_acc[2*XLEN-1:XLEN];
                lo_d = qneg_q ? -core_acc[XLEN-1:0] : core_acc[XLEN-1:0];
            end else begin
                prod = qneg_q ? -core_acc : core_acc;
                hi_d = prod[2*XLEN-1:XLEN];
                lo_d = prod[XLEN-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!clrn) begin
            hi_q   <= '0;
            lo_q   <= '0;
            qneg_q <= 1'b0;
            rneg_q <= 1'b0;
            div_q  <= 1'b0;
        end else begin
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            qneg_q <= qneg_d;
            rneg_q <= rneg_d;
            div_q  <= div_d;
        end
    end

    assign bus.rdata = bus.mfhi ? hi_q : (bus.mflo ? lo_q : '0);
    assign bus.busy  = busy_q;
    assign bus.stall = busy_q & (bus.start | bus.mfhi | bus.mflo | bus.mthi | bus.mtlo);
    assign state_dbg = state_q;

endmodule

// File: tb/tb_pipe_muldiv_hilo.sv
// Self-checking bench for pipe_muldiv_hilo: cycle-level behavioural model of
// HI/LO and busy, directed edge cases and randomized traffic.
module tb_pipe_muldiv_hilo;
    import muldiv_pkg::*;

    localparam int XLEN = 32;
    localparam int ITER = 32;

    // ---------------- clock / reset ----------------
    logic      clk  = 1'b0;
    logic      clrn = 1'b0;
    md_state_e state_dbg;

    always #5 clk = ~clk;

    pipe_muldiv_hilo_if #(.XLEN(XLEN)) bus();

    pipe_muldiv_hilo #(
        .XLEN (XLEN),
        .ITER (ITER)
    ) dut (
        .clk       (clk),
        .clrn      (clrn),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    int n_cmp  = 0;
    int n_err  = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic void ref_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] hi, output logic [31:0] lo);
        longint     sa, sb;
        logic [63:0] p;
        int         ia, ib;
        p = '0;
        if (op[1] == 1'b0) begin
            if (op[0] == 1'b0) begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
                p  = 64'(sa * sb);
            end else begin
                p = {32'h0, a} * {32'h0, b};
            end
            hi = p[63:32];
            lo = p[31:0];
        end else if (b == 32'h0) begin
            hi = a;
            lo = 32'hFFFF_FFFF;
        end else if (op[0] == 1'b1) begin
            hi = a % b;
            lo = a / b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            hi = 32'h0;
            lo = 32'h8000_0000;
        end else begin
            ia = $signed(a);
            ib = $signed(b);
            hi = 32'(ia % ib);
            lo = 32'(ia / ib);
        end
    endfunction

    logic [31:0] m_hi   = '0;
    logic [31:0] m_lo   = '0;
    int          m_left = 0;
    logic [31:0] exp_q[$];

    always @(posedge clk) begin
        logic [31:0] h, l;
        if (!clrn) begin
            m_hi   = '0;
            m_lo   = '0;
            m_left = 0;
            exp_q.delete();
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0 && exp_q.size() >= 2) begin
                m_hi = exp_q.pop_front();
                m_lo = exp_q.pop_front();
            end
        end else begin
            if (bus.mthi) m_hi = bus.wd;
            if (bus.mtlo) m_lo = bus.wd;
            if (bus.start) begin
                ref_op(bus.op, bus.a, bus.b, h, l);
                exp_q.push_back(h);
                exp_q.push_back(l);
                m_left = ITER + 1;
            end
        end
    end

    // ---------------- scoreboard compare ----------------
    always @(negedge clk) begin
        logic exp_busy;
        if (chk_en) begin
            exp_busy = (m_left > 0);
            check("busy", {31'h0, bus.busy}, {31'h0, exp_busy});
            check("stall", {31'h0, bus.stall},
                  {31'h0, exp_busy & (bus.start | bus.mfhi | bus.mflo | bus.mthi | bus.mtlo)});
            if (!exp_busy)
                check("rdata", bus.rdata, bus.mfhi ? m_hi : (bus.mflo ? m_lo : 32'h0));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        bus.start = 1'b0;
        bus.op    = 2'b00;
        bus.a     = '0;
        bus.b     = '0;
        bus.mfhi  = 1'b0;
        bus.mflo  = 1'b0;
        bus.mthi  = 1'b0;
        bus.mtlo  = 1'b0;
        bus.wd    = '0;
    endtask

    task automatic read_hilo(input string name, input logic [31:0] eh, input logic [31:0] el);
        bus.mfhi = 1'b1;
        @(negedge clk);
        check({name, "_hi"}, bus.rdata, eh);
        cyc();
        bus.mfhi = 1'b0;
        bus.mflo = 1'b1;
        @(negedge clk);
        check({name, "_lo"}, bus.rdata, el);
        cyc();
        bus.mflo = 1'b0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (bus.busy && n < 100) begin
            n++;
            cyc();
        end
    endtask

    task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el);
        int n;
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        cyc();
        clear_in();
        wait_idle(n);
        check({name, "_busy_len"}, 32'(n), 32'(ITER + 1));
        read_hilo(name, eh, el);
    endtask

    function automatic logic [31:0] rand_val();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        int n;
        clear_in();
        clrn = 1'b0;
        repeat (3) cyc();
        chk_en = 1'b1;
        check("reset_busy", {31'h0, bus.busy}, 32'h0);
        check("reset_state", {30'h0, state_dbg}, {30'h0, S_IDLE});
        clrn = 1'b1;
        read_hilo("reset", 32'h0, 32'h0);

        run_op("mult",   MD_MULT,  32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        run_op("multu",  MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        run_op("div",    MD_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("divu0",  MD_DIVU,  32'h0000_1234, 32'h0000_0000, 32'h0000_1234, 32'hFFFF_FFFF);
        run_op("div0",   MD_DIV,   32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF);
        run_op("divovf", MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
        run_op("divrem", MD_DIV,   32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD);

        // Hazard: mflo right behind a mult, plus a rejected second start.
        bus.start = 1'b1;
        bus.op    = MD_MULTU;
        bus.a     = 32'd5;
        bus.b     = 32'd6;
        cyc();
        clear_in();
        bus.mflo = 1'b1;
        bus.op   = MD_DIVU;
        bus.a    = 32'd100;
        bus.b    = 32'd7;
        n = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!bus.stall) break;
            n++;
            cyc();
            bus.start = (n == 5);
        end
        check("hazard_stall_len", 32'(n), 32'(ITER + 1));
        check("hazard_first_lo", bus.rdata, 32'd30);
        cyc();
        clear_in();
        read_hilo("hazard", 32'h0, 32'd30);

        // Reset in the middle of an operation abandons it.
        bus.start = 1'b1;
        bus.op    = MD_MULT;
        bus.a     = 32'h1234_5678;
        bus.b     = 32'h0000_0009;
        cyc();
        clear_in();
        repeat (10) cyc();
        clrn = 1'b0;
        cyc();
        clrn = 1'b1;
        check("midrst_busy", {31'h0, bus.busy}, 32'h0);
        read_hilo("midrst", 32'h0, 32'h0);
        repeat (40) cyc();
        read_hilo("midrst_late", 32'h0, 32'h0);

        // Move-to paths.
        bus.mthi = 1'b1;
        bus.wd   = 32'hA5A5_A5A5;
        cyc();
        clear_in();
        read_hilo("mthi", 32'hA5A5_A5A5, 32'h0);
        bus.mthi = 1'b1;
        bus.mfhi = 1'b1;
        bus.wd   = 32'h1111_1111;
        @(negedge clk);
        check("mthi_same_cycle", bus.rdata, 32'hA5A5_A5A5);
        cyc();
        clear_in();
        read_hilo("mthi2", 32'h1111_1111, 32'h0);
        bus.mtlo = 1'b1;
        bus.wd   = 32'hDEAD_BEEF;
        run_op("mtlo_start", MD_MULTU, 32'd3, 32'd4, 32'h0, 32'd12);

        // Randomized traffic, checked every cycle by the scoreboard.
        for (int i = 0; i < 3000; i++) begin
            bus.start = ($urandom_range(0, 7) == 0);
            bus.op    = 2'($urandom_range(0, 3));
            bus.a     = rand_val();
            bus.b     = rand_val();
            bus.mfhi  = ($urandom_range(0, 3) == 0);
            bus.mflo  = ($urandom_range(0, 3) == 0);
            bus.mthi  = ($urandom_range(0, 15) == 0);
            bus.mtlo  = ($urandom_range(0, 15) == 0);
            bus.wd    = $urandom;
            cyc();
        end
        clear_in();
        wait_idle(n);
        check("final_idle", {31'h0, bus.busy}, 32'h0);
        read_hilo("final", m_hi, m_lo);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
